// File: rtl/alarm_unit.sv
`timescale 1ns/1ps
// alarm_unit: user-set alarm time, IDLE/RING(/SNOOZE) controller and gated square-wave buzzer.
// Define ALARM_SNOOZE_EN to compile in the SNOOZE state and its countdown.
module alarm_unit #(
  parameter int CLK_HZ     = 50000000,
  parameter int TONE_HZ    = 1000,
  parameter int RING_SEC   = 30,
  parameter int SNOOZE_SEC = 300
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_tick_1hz,
  input  logic [4:0] i_hour,
  input  logic [5:0] i_min,
  input  logic [5:0] i_sec,
  input  logic       i_set_en,
  input  logic       i_pos,
  input  logic       i_inc,
  input  logic       i_arm_tgl,
  input  logic       i_stop,
  input  logic       i_snooze,
  output logic [4:0] o_alarm_hour,
  output logic [5:0] o_alarm_min,
  output logic       o_armed,
  output logic       o_ringing,
  output logic       o_snoozing,
  output logic       o_buzz
);

  localparam int HALF = CLK_HZ / (2 * TONE_HZ);
  localparam int TW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int RW   = $clog2(RING_SEC + 1);

`ifdef ALARM_SNOOZE_EN
  localparam int SW = $clog2(SNOOZE_SEC + 1);
  typedef enum logic [1:0] {IDLE = 2'd0, RING = 2'd1, SNOOZE = 2'd2} state_t;
  logic [SW-1:0] snz_cnt, snz_cnt_d;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RING = 2'd1} state_t;
  logic unused_snooze;
  assign unused_snooze = i_snooze;
`endif

  state_t        state, state_d;
  logic [4:0]    alarm_hour_d;
  logic [5:0]    alarm_min_d;
  logic [RW-1:0] ring_cnt, ring_cnt_d;
  logic [TW-1:0] tone_cnt, tone_cnt_d;
  logic          tone, tone_d;
  logic          buzz_d;
  logic          disarm, match;

  always_comb begin
    state_d      = state;
    alarm_hour_d = o_alarm_hour;
    alarm_min_d  = o_alarm_min;
    ring_cnt_d   = ring_cnt;
    tone_cnt_d   = '0;
    tone_d       = 1'b0;
`ifdef ALARM_SNOOZE_EN
    snz_cnt_d    = snz_cnt;
`endif
    disarm = i_arm_tgl & o_armed;
    match  = o_armed & i_tick_1hz & ~i_set_en & (i_hour == o_alarm_hour) &
             (i_min == o_alarm_min) & (i_sec == 6'd0);

    if (i_set_en && i_inc && state == IDLE) begin
      if (i_pos)
        alarm_hour_d = (o_alarm_hour == 5'd23) ? 5'd0 : o_alarm_hour + 5'd1;
      else
        alarm_min_d = (o_alarm_min == 6'd59) ? 6'd0 : o_alarm_min + 6'd1;
    end

    // Disarm outranks stop, stop outranks snooze, snooze outranks timeout.
    case (state)
      IDLE: begin
        if (match && !disarm) state_d = RING;
      end
      RING: begin
        if (disarm || i_stop) begin
          state_d = IDLE;
`ifdef ALARM_SNOOZE_EN
        end else if (i_snooze) begin
          state_d   = SNOOZE;
          snz_cnt_d = SW'(SNOOZE_SEC);
`endif
        end else if (i_tick_1hz) begin
          if (ring_cnt == RW'(RING_SEC - 1)) state_d = IDLE;
          else ring_cnt_d = ring_cnt + 1'b1;
        end
      end
`ifdef ALARM_SNOOZE_EN
      SNOOZE: begin
        if (disarm || i_stop) begin
          state_d = IDLE;
        end else if (i_tick_1hz) begin
          snz_cnt_d = snz_cnt - 1'b1;
          if (snz_cnt == SW'(1)) state_d = RING;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

`ifdef ALARM_SNOOZE_EN
    if (state_d != SNOOZE) snz_cnt_d = '0;
`endif
    if (state_d != RING) ring_cnt_d = '0;

    // Tone only runs while staying in RING, so every entry starts at phase 0.
    if (state == RING && state_d == RING) begin
      if (tone_cnt == TW'(HALF - 1)) begin
        tone_cnt_d = '0;
        tone_d     = ~tone;
      end else begin
        tone_cnt_d = tone_cnt + 1'b1;
        tone_d     = tone;
      end
    end

    buzz_d = (state_d == RING) & tone_d & ~ring_cnt_d[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      o_alarm_hour <= '0;
      o_alarm_min  <= '0;
      o_armed      <= 1'b0;
      ring_cnt     <= '0;
      tone_cnt     <= '0;
      tone         <= 1'b0;
      o_ringing    <= 1'b0;
      o_snoozing   <= 1'b0;
      o_buzz       <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt      <= '0;
`endif
    end else begin
      state        <= state_d;
      o_alarm_hour <= alarm_hour_d;
      o_alarm_min  <= alarm_min_d;
      o_armed      <= o_armed ^ i_arm_tgl;
      ring_cnt     <= ring_cnt_d;
      tone_cnt     <= tone_cnt_d;
      tone         <= tone_d;
      o_ringing    <= (state_d == RING);
      o_buzz       <= buzz_d;
`ifdef ALARM_SNOOZE_EN
      snz_cnt      <= snz_cnt_d;
      o_snoozing   <= (state_d == SNOOZE);
`else
      o_snoozing   <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_alarm_unit.sv
`timescale 1ns/1ps
// tb_alarm_unit: directed and random stimulus checked every cycle against a behavioural alarm model.
module tb_alarm_unit;
  localparam int CLK_HZ = 1000, TONE_HZ = 100, RING_SEC = 4, SNOOZE_SEC = 3;
  localparam int HALF = CLK_HZ / (2 * TONE_HZ);
`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ = 1'b1;
`else
  localparam bit SNZ = 1'b0;
`endif

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       i_tick_1hz = 0, i_set_en = 0, i_pos = 0, i_inc = 0;
  logic       i_arm_tgl = 0, i_stop = 0, i_snooze = 0;
  logic [4:0] i_hour = 0;
  logic [5:0] i_min = 0, i_sec = 0;
  logic [4:0] o_alarm_hour;
  logic [5:0] o_alarm_min;
  logic       o_armed, o_ringing, o_snoozing, o_buzz;

  always #5 clk = ~clk;

  alarm_unit #(.CLK_HZ(CLK_HZ), .TONE_HZ(TONE_HZ), .RING_SEC(RING_SEC), .SNOOZE_SEC(SNOOZE_SEC)) dut (
    .clk(clk), .rst_n(rst_n), .i_tick_1hz(i_tick_1hz), .i_hour(i_hour), .i_min(i_min),
    .i_sec(i_sec), .i_set_en(i_set_en), .i_pos(i_pos), .i_inc(i_inc), .i_arm_tgl(i_arm_tgl),
    .i_stop(i_stop), .i_snooze(i_snooze), .o_alarm_hour(o_alarm_hour), .o_alarm_min(o_alarm_min),
    .o_armed(o_armed), .o_ringing(o_ringing), .o_snoozing(o_snoozing), .o_buzz(o_buzz)
  );

  int n_vec = 0, n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: state 0=idle 1=ring 2=snooze; m_k = cycles since ring entry.
  int m_hour = 0, m_min = 0, m_st = 0, m_rsec = 0, m_k = 0, m_snz = 0;
  bit m_armed = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hour = 0; m_min = 0; m_st = 0; m_rsec = 0; m_k = 0; m_snz = 0; m_armed = 0;
    end else begin : upd
      int nst;
      bit enter, disarm, match;
      disarm = i_arm_tgl && m_armed;
      match  = m_armed && i_tick_1hz && !i_set_en && (i_hour == m_hour) &&
               (i_min == m_min) && (i_sec == 0);
      nst = m_st;
      enter = 0;
      if (m_st == 0 && i_set_en && i_inc) begin
        if (i_pos) m_hour = (m_hour + 1) % 24;
        else m_min = (m_min + 1) % 60;
      end
      if (m_st == 0) begin
        if (match && !disarm) begin nst = 1; enter = 1; end
      end else if (disarm || i_stop) begin
        nst = 0;
      end else if (m_st == 1) begin
        if (SNZ && i_snooze) begin
          nst = 2; m_snz = SNOOZE_SEC;
        end else if (i_tick_1hz) begin
          m_rsec++;
          if (m_rsec == RING_SEC) nst = 0;
        end
      end else if (i_tick_1hz) begin
        m_snz--;
        if (m_snz == 0) begin nst = 1; enter = 1; end
      end
      if (i_arm_tgl) m_armed = !m_armed;
      if (enter) begin m_rsec = 0; m_k = 0; end
      else if (nst == 1) m_k++;
      m_st = nst;
    end
  end

  function automatic int exp_buzz();
    return (m_st == 1 && ((m_k / HALF) % 2 == 1) && (m_rsec % 2 == 0)) ? 1 : 0;
  endfunction

  bit cmp_en = 0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("alarm_hour", o_alarm_hour, m_hour);
      chk("alarm_min", o_alarm_min, m_min);
      chk("armed", o_armed, m_armed);
      chk("ringing", o_ringing, (m_st == 1) ? 1 : 0);
      chk("snoozing", o_snoozing, (m_st == 2) ? 1 : 0);
      chk("buzz", o_buzz, exp_buzz());
    end
  end

  // All helpers start and end right after a falling edge.
  task automatic pulse_inc(input bit pos);
    i_set_en = 1; i_pos = pos; i_inc = 1;
    @(negedge clk);
    i_inc = 0;
  endtask

  task automatic pulse_arm();
    i_arm_tgl = 1;
    @(negedge clk);
    i_arm_tgl = 0;
  endtask

  task automatic tick(input int h, input int m, input int s);
    i_hour = 5'(h); i_min = 6'(m); i_sec = 6'(s); i_tick_1hz = 1;
    @(negedge clk);
    i_tick_1hz = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ringing", o_ringing, 0);
    chk("rst_buzz", o_buzz, 0);
    chk("rst_armed", o_armed, 0);
    chk("rst_hour", o_alarm_hour, 0);
    chk("rst_min", o_alarm_min, 0);
    rst_n = 1;
    cmp_en = 1;
    @(negedge clk);

    repeat (60) pulse_inc(0);
    chk("wrap_min", o_alarm_min, 0);
    chk("wrap_hour_nocarry", o_alarm_hour, 0);
    repeat (25) pulse_inc(1);
    chk("wrap_hour", o_alarm_hour, 1);
    repeat (6) pulse_inc(1);
    repeat (30) pulse_inc(0);
    i_set_en = 0;
    chk("set_hour", o_alarm_hour, 7);
    chk("set_min", o_alarm_min, 30);
    pulse_arm();
    chk("arm", o_armed, 1);

    tick(7, 30, 0);
    chk("trig_ring", o_ringing, 1);
    chk("trig_buzz0", o_buzz, 0);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 4) chk("buzz_k4", o_buzz, 0);
      if (n == 5) chk("buzz_k5", o_buzz, 1);
      if (n == 9) chk("buzz_k9", o_buzz, 1);
      if (n == 10) chk("buzz_k10", o_buzz, 0);
    end
    tick(7, 30, 5);
    for (int n = 0; n < 12; n++) begin
      chk("silent_sec", o_buzz, 0);
      @(negedge clk);
    end
    tick(7, 30, 6);
    tick(7, 30, 7);
    chk("ring_after3", o_ringing, 1);
    tick(7, 30, 8);
    chk("timeout", o_ringing, 0);

    tick(7, 30, 1);
    chk("no_trig_sec1", o_ringing, 0);
    pulse_arm();
    chk("disarm", o_armed, 0);
    tick(7, 30, 0);
    chk("no_trig_disarmed", o_ringing, 0);
    pulse_arm();

    tick(7, 30, 0);
    chk("ring_again", o_ringing, 1);
    i_stop = 1; i_snooze = 1;
    @(negedge clk);
    i_stop = 0; i_snooze = 0;
    chk("stop_prio_ring", o_ringing, 0);
    chk("stop_prio_snz", o_snoozing, 0);
    chk("stop_prio_buzz", o_buzz, 0);

    if (SNZ) begin
      tick(7, 30, 0);
      i_snooze = 1;
      @(negedge clk);
      i_snooze = 0;
      chk("snooze_on", o_snoozing, 1);
      chk("snooze_ring_off", o_ringing, 0);
      tick(7, 31, 1);
      tick(7, 31, 2);
      chk("snooze_hold", o_snoozing, 1);
      tick(7, 31, 3);
      chk("snooze_rering", o_ringing, 1);
      chk("snooze_off", o_snoozing, 0);
      i_snooze = 1;
      @(negedge clk);
      i_snooze = 0;
      pulse_arm();
      chk("snz_disarm_idle", o_snoozing, 0);
      chk("snz_disarm_armed", o_armed, 0);
      pulse_arm();
    end

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 1) == 0) begin
        i_hour = 5'(m_hour); i_min = 6'(m_min); i_sec = 6'd0;
      end else begin
        i_hour = 5'($urandom_range(0, 23)); i_min = 6'($urandom_range(0, 59));
        i_sec = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom_range(0, 59));
      end
      i_tick_1hz = ($urandom_range(0, 3) == 0);
      i_set_en   = ($urandom_range(0, 15) == 0);
      i_inc      = ($urandom_range(0, 3) == 0);
      i_pos      = 1'($urandom_range(0, 1));
      i_arm_tgl  = ($urandom_range(0, 39) == 0);
      i_stop     = ($urandom_range(0, 29) == 0);
      i_snooze   = ($urandom_range(0, 14) == 0);
      @(negedge clk);
    end
    i_tick_1hz = 0; i_set_en = 0; i_inc = 0; i_arm_tgl = 0; i_stop = 0; i_snooze = 0;

    i_stop = 1;
    @(negedge clk);
    i_stop = 0;
    if (!m_armed) pulse_arm();
    tick(m_hour, m_min, 0);
    begin : wait_buzz
      int cnt;
      cnt = 0;
      while (o_buzz !== 1'b1 && cnt < 30) begin
        @(negedge clk);
        cnt++;
      end
      chk("buzz_before_reset", o_buzz, 1);
    end
    #2 rst_n = 0;
    #1;
    chk("rst_async_buzz", o_buzz, 0);
    chk("rst_async_ringing", o_ringing, 0);
    chk("rst_async_armed", o_armed, 0);
    chk("rst_async_hour", o_alarm_hour, 0);
    chk("rst_async_min", o_alarm_min, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alarm_unit.md
# alarm_unit

Alarm stage sitting directly downstream of the hour/minute/second counters in the digital clock. It holds a user-set alarm time and compares it against the running time each second. On a match it drives a gated square-wave buzzer output until stopped, timed out, or snoozed. It also exports the alarm time so the display path can show it in alarm-setup mode.

## Interface
Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- TONE_HZ, 1000, buzzer tone frequency in Hz; half-period HALF = CLK_HZ/(2*TONE_HZ) cycles.
- RING_SEC, 30, seconds of ringing before automatic stop.
- SNOOZE_SEC, 300, snooze length in seconds.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- i_tick_1hz  input  1  one-clk-cycle pulse, once per second, clk domain.
- i_hour  input  5  current hour, 0..23.
- i_min  input  6  current minute, 0..59.
- i_sec  input  6  current second, 0..59.
- i_set_en  input  1  alarm-setup mode active (level).
- i_pos  input  1  field being set: 0 = minute, 1 = hour.
- i_inc  input  1  one-cycle pulse; increments the selected alarm field.
- i_arm_tgl  input  1  one-cycle pulse; toggles the armed flag.
- i_stop  input  1  one-cycle pulse; stops ringing or snooze.
- i_snooze  input  1  one-cycle pulse; snooze request (used only when snooze is compiled in).
- o_alarm_hour  output  5  alarm hour.
- o_alarm_min  output  6  alarm minute.
- o_armed  output  1  alarm armed.
- o_ringing  output  1  state is RING.
- o_snoozing  output  1  state is SNOOZE; constant 0 without ALARM_SNOOZE_EN.
- o_buzz  output  1  buzzer drive.

## Operation
- Reset values: alarm time 00:00, o_armed=0, state IDLE, o_ringing=0, o_snoozing=0, o_buzz=0, all internal counters 0.
- Alarm setting applies only when i_set_en=1 and the state is IDLE. Otherwise i_inc is ignored.
  - With i_pos=0, i_inc increments the minute 0..59 and wraps 59→0. The hour is not carried.
  - With i_pos=1, i_inc increments the hour 0..23 and wraps 23→0.
- i_arm_tgl toggles o_armed in any state.
- FSM states are IDLE, RING, and SNOOZE.
- IDLE→RING when all of the following hold in the same cycle:
  - o_armed=1.
  - i_tick_1hz=1.
  - i_hour==alarm hour, i_min==alarm minute, and i_sec==0.
  - i_set_en=0.
  - If the clock is set past hh:mm:00 without a tick at sec 0, the alarm is missed by design.
- On RING entry: ring-second counter := 0 and tone phase := 0.
- In RING:
  - Each tick increments the ring-second counter.
  - RING→IDLE when i_stop=1, or on the tick that brings the counter to RING_SEC.
- Beep gating: o_buzz = tone AND (ring-second counter LSB == 0). This gives 1 s of tone followed by 1 s of silence.
- The tone counter counts 0..HALF-1. On terminal count, tone toggles and the counter reloads to 0. The tone counter is held at 0 outside RING.
- o_buzz=0 in every state other than RING.
- Event priority within one cycle:
  1. Disarm via i_arm_tgl while armed: forces IDLE from any state and suppresses a simultaneous match.
  2. i_stop.
  3. i_snooze.
  4. Timeout.
- A match occurring while in RING or SNOOZE is ignored.

## Timing
- All outputs are registered.
- o_ringing rises the cycle after the matching tick.
- o_buzz first rises HALF cycles after RING entry.
- i_stop → o_ringing=0 and o_buzz=0 on the next cycle.
- Timeout: o_ringing falls the cycle after the RING_SEC-th tick counted in RING.
- Alarm field update is visible on o_alarm_* the cycle after i_inc.
- o_armed changes the cycle after i_arm_tgl.
- Reset asserted mid-ring clears o_buzz and o_ringing immediately (asynchronous) and clears the armed flag.

## Configuration
- ALARM_SNOOZE_EN defined:
  - i_snooze in RING → SNOOZE, with snooze counter := SNOOZE_SEC.
  - Each tick in SNOOZE decrements the counter. The tick that brings it to 0 moves to RING, with the ring counter and tone phase reset.
  - i_stop in SNOOZE → IDLE.
  - o_snoozing is high in SNOOZE.
- ALARM_SNOOZE_EN undefined:
  - No SNOOZE state and no snooze counter.
  - i_snooze is ignored and o_snoozing is tied 0.

## Test plan
All scenarios use CLK_HZ=1000, TONE_HZ=100 (HALF=5), RING_SEC=4, SNOOZE_SEC=3.
- Setup wrap: i_set_en=1, i_pos=0, 60 i_inc pulses → minute returns to 0 and hour stays 0. With i_pos=1, 25 pulses → hour=1.
- Trigger: alarm 07:30, armed, tick with time 07:30:00 → o_ringing=1 next cycle. o_buzz toggles every 5 cycles for the first 1 s and is 0 during the second second.
- Timeout and no-trigger: ringing ends after the 4th tick in RING. A tick at 07:30:01 or with o_armed=0 → stays IDLE.
- Stop priority: i_stop and i_snooze in the same cycle during RING → IDLE, o_snoozing stays 0.
- Snooze (ALARM_SNOOZE_EN): i_snooze in RING → o_snoozing=1. After 3 ticks → o_ringing=1 again. i_arm_tgl during SNOOZE → IDLE and o_armed=0.
- Reset mid-ring: rst_n low while o_buzz=1 → all outputs 0 immediately and alarm time 00:00.
